// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB bus bundle between a master and the register-file completer
interface apb_slave_regfile_if;
    logic        psel_i;
    logic        penable_i;
    logic [31:0] paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [3:0]  wait_cfg_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, wait_cfg_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, wait_cfg_i,
        input  prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer over a 32-bit register file with programmable wait states
module apb_slave_regfile #(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               pclk_i,
    input  logic               prst_n,
    apb_slave_regfile_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);

    // The setup phase is recognised on the bus while idle, so the state after
    // the setup edge is already ACCESS and back-to-back transfers need no gap.
    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               pready_q, pready_d;
    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic               err_q;
    logic [31:0]        regs_q [NUM_REGS];

    logic               setup_take;
    logic               complete;
    logic               wr_en;
    logic [32:0]        offset;
    logic               addr_err;

    // A borrow out of the subtraction means the address sits below the window.
    assign offset   = {1'b0, bus.paddr_i} - {1'b0, BASE_ADDR};
    assign addr_err = (bus.paddr_i[1:0] != 2'b00) || offset[32] ||
                      (offset[31:0] >= 32'(NUM_REGS * 4));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pready_d   = pready_q;
        setup_take = 1'b0;
        complete   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.psel_i && !bus.penable_i) begin
                    state_d    = S_ACCESS;
                    setup_take = 1'b1;
                    cnt_d      = bus.wait_cfg_i;
                    pready_d   = (bus.wait_cfg_i == 4'd0);
                end
            end
            S_ACCESS: begin
                if (!bus.psel_i) begin
                    state_d  = S_IDLE;
                    cnt_d    = 4'd0;
                    pready_d = 1'b0;
                end else if (bus.penable_i && pready_q) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = 4'd0;
                    pready_d = 1'b0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d    = cnt_q - 4'd1;
                    pready_d = (cnt_q == 4'd1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = 4'd0;
                pready_d = 1'b0;
            end
        endcase
    end

    assign wr_en = complete && wr_q && !err_q;

    always_ff @(posedge pclk_i) begin
        if (!prst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            pready_q <= 1'b0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pready_q <= pready_d;
            if (setup_take) begin
                idx_q <= bus.paddr_i[IDX_W+1:2];
                wr_q  <= bus.pwrite_i;
                err_q <= addr_err;
            end
            if (wr_en) begin
                regs_q[idx_q] <= bus.pwdata_i;
            end
        end
    end

    // Read data comes straight from the array so a write committed on the
    // previous edge is already visible in this completion cycle.
    assign bus.pready_o  = pready_q;
    assign bus.pslverr_o = pready_q && err_q;
    assign bus.prdata_o  = (pready_q && !wr_q && !err_q) ? regs_q[idx_q] : 32'd0;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed self-checking bench for apb_slave_regfile
module tb_apb_slave_regfile;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          NREG = 16;

    logic pclk;
    logic prst_n;
    int   pass_cnt;
    int   total_cnt;
    int   pulses;

    apb_slave_regfile_if bus();

    apb_slave_regfile #(
        .NUM_REGS  (NREG),
        .BASE_ADDR (BASE)
    ) dut (
        .pclk_i (pclk),
        .prst_n (prst_n),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (bus.pready_o) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] wcfg, output logic [31:0] rdata,
                        output logic err, output int acc);
        bus.psel_i     = 1'b1;
        bus.penable_i  = 1'b0;
        bus.pwrite_i   = wr;
        bus.paddr_i    = addr;
        bus.pwdata_i   = data;
        bus.wait_cfg_i = wcfg;
        tick();
        bus.penable_i  = 1'b1;
        bus.wait_cfg_i = ~wcfg;
        bus.paddr_i    = ~addr;
        acc = 1;
        while (!bus.pready_o && acc < 40) begin
            tick();
            acc++;
        end
        rdata = bus.prdata_o;
        err   = bus.pslverr_o;
        bus.paddr_i = addr;
        tick();
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          acc;
    logic [31:0] model [NREG];
    logic        wr;
    int          idx;
    logic [31:0] dat;
    logic [3:0]  wc;
    logic        seen;

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        pulses = 0;
        prst_n = 1'b0;
        bus.psel_i = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i = 1'b0;
        bus.paddr_i = 32'd0;
        bus.pwdata_i = 32'd0;
        bus.wait_cfg_i = 4'd0;
        tick(); tick(); tick();
        check("rst_pready", {31'd0, bus.pready_o}, 32'd0);
        check("rst_pslverr", {31'd0, bus.pslverr_o}, 32'd0);
        check("rst_prdata", bus.prdata_o, 32'd0);
        prst_n = 1'b1;
        bus.penable_i = 1'b1;
        tick(); tick();
        check("idle_penable_ignored", {31'd0, bus.pready_o}, 32'd0);
        bus.penable_i = 1'b0;

        xfer(1'b1, BASE + 32'd8, 32'hDEADBEEF, 4'd0, rd, er, acc);
        check("w0_len", 32'(acc), 32'd1);
        check("w0_err", {31'd0, er}, 32'd0);
        check("w0_prdata", rd, 32'd0);
        xfer(1'b0, BASE + 32'd8, 32'd0, 4'd0, rd, er, acc);
        check("r0_len", 32'(acc), 32'd1);
        check("r0_data", rd, 32'hDEADBEEF);

        xfer(1'b1, BASE + 32'd4, 32'hA5A5_0001, 4'd0, rd, er, acc);
        xfer(1'b0, BASE + 32'd4, 32'd0, 4'd5, rd, er, acc);
        check("r5_len", 32'(acc), 32'd6);
        check("r5_data", rd, 32'hA5A5_0001);
        xfer(1'b0, BASE + 32'd4, 32'd0, 4'd15, rd, er, acc);
        check("r15_len", 32'(acc), 32'd16);
        check("r15_data", rd, 32'hA5A5_0001);

        xfer(1'b1, BASE, 32'h0000_00AA, 4'd0, rd, er, acc);
        xfer(1'b1, BASE + 32'd60, 32'h0000_00FF, 4'd1, rd, er, acc);
        xfer(1'b1, BASE + 32'd2, 32'h1234, 4'd0, rd, er, acc);
        check("mis_err", {31'd0, er}, 32'd1);
        check("mis_prdata", rd, 32'd0);
        xfer(1'b1, BASE + 32'd64, 32'h1234, 4'd2, rd, er, acc);
        check("oor_err", {31'd0, er}, 32'd1);
        check("oor_len", 32'(acc), 32'd3);
        xfer(1'b0, BASE - 32'd4, 32'd0, 4'd0, rd, er, acc);
        check("below_err", {31'd0, er}, 32'd1);
        check("below_prdata", rd, 32'd0);
        xfer(1'b0, BASE, 32'd0, 4'd0, rd, er, acc);
        check("reg0_kept", rd, 32'h0000_00AA);
        check("reg0_err", {31'd0, er}, 32'd0);
        xfer(1'b0, BASE + 32'd60, 32'd0, 4'd0, rd, er, acc);
        check("reg15_kept", rd, 32'h0000_00FF);

        xfer(1'b1, BASE + 32'd12, 32'h3333, 4'd0, rd, er, acc);
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1;
        bus.paddr_i = BASE + 32'd12; bus.pwdata_i = 32'hBAD; bus.wait_cfg_i = 4'd4;
        tick();
        bus.penable_i = 1'b1;
        seen = bus.pready_o;
        tick();
        seen = seen | bus.pready_o;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | bus.pready_o;
        end
        check("abort_no_pready", {31'd0, seen}, 32'd0);
        xfer(1'b0, BASE + 32'd12, 32'd0, 4'd1, rd, er, acc);
        check("abort_len", 32'(acc), 32'd2);
        check("abort_reg_kept", rd, 32'h3333);

        for (int i = 0; i < NREG; i++) model[i] = 32'd0;
        for (int i = 0; i < NREG; i++) begin
            xfer(1'b1, BASE + 32'(i * 4), 32'h5000_0000 + 32'(i), 4'd0, rd, er, acc);
            model[i] = 32'h5000_0000 + 32'(i);
        end
        pulses = 0;
        for (int n = 0; n < 32; n++) begin
            wr  = 1'($urandom_range(1, 0));
            idx = int'($urandom_range(NREG - 1, 0));
            dat = $urandom;
            wc  = 4'($urandom_range(10, 0));
            xfer(wr, BASE + 32'(idx * 4), dat, wc, rd, er, acc);
            check($sformatf("b2b_len_%0d", n), 32'(acc), 32'(wc) + 32'd1);
            if (wr) model[idx] = dat;
            else check($sformatf("b2b_rd_%0d", n), rd, model[idx]);
        end
        check("b2b_pulses", 32'(pulses), 32'd32);

        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1;
        bus.paddr_i = BASE + 32'd20; bus.pwdata_i = 32'hFFFF_0000; bus.wait_cfg_i = 4'd6;
        tick();
        bus.penable_i = 1'b1;
        tick();
        prst_n = 1'b0;
        tick();
        check("rst_mid_pready", {31'd0, bus.pready_o}, 32'd0);
        tick();
        prst_n = 1'b1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        tick();
        for (int i = 0; i < NREG; i++) begin
            xfer(1'b0, BASE + 32'(i * 4), 32'd0, 4'd0, rd, er, acc);
            check($sformatf("rst_reg_%0d", i), rd, 32'd0);
            check($sformatf("rst_err_%0d", i), {31'd0, er}, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
